// File: rtl/cpu_run_sequencer_pkg.sv
// Shared types and default timing for the CPU run/inspect sequencer.
// Holds the FSM state encoding and the saturating run-cycle increment.
package cpu_run_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_VIEW,
    S_DONE
  } seq_state_t;

  localparam int unsigned DEF_DATA_W        = 32;
  localparam int unsigned DEF_SEL_W         = 4;
  localparam int unsigned DEF_RST_CYCLES    = 5;
  localparam int unsigned DEF_RUN_CYCLES    = 75;
  localparam int unsigned DEF_DWELL_CYCLES  = 2;
  localparam int unsigned DEF_NUM_VIEW_REGS = 10;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cpu_run_sequencer_counter.sv
// Loadable down counter with zero flag; used for reset, run-limit and dwell timing.
// Decrement stops at zero so a held dec never wraps.
module seq_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cpu_run_sequencer.sv
// Run/inspect controller for CPU_FPGA: hold in reset, run for a bounded time,
// then scan registers through output_sel and stream captured words out.
module cpu_run_sequencer
  import cpu_run_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned SEL_W         = DEF_SEL_W,
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned RUN_CYCLES    = DEF_RUN_CYCLES,
  parameter int unsigned DWELL_CYCLES  = DEF_DWELL_CYCLES,
  parameter int unsigned NUM_VIEW_REGS = DEF_NUM_VIEW_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              halt_in,
  input  logic [DATA_W-1:0] cpu_output,
  output logic              cpu_rst,
  output logic [SEL_W-1:0]  output_sel,
  output logic              rd_valid,
  output logic [SEL_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       run_cycles
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam int unsigned LW = $clog2(RUN_CYCLES + 1);
  localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);

  // Counters load N-1 (or DWELL) so the zero flag marks the final cycle of a phase.
  localparam logic [RW-1:0]    RST_LOAD   = RW'(RST_CYCLES - 1);
  localparam logic [LW-1:0]    RUN_LOAD   = LW'(RUN_CYCLES - 1);
  localparam logic [DW-1:0]    DWELL_LOAD = DW'(DWELL_CYCLES);
  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_VIEW_REGS - 1);

  seq_state_t state, next_state;
  logic [SEL_W-1:0] idx;
  logic rst_load, rst_dec, rst_zero;
  logic run_load, run_dec, run_zero;
  logic dwell_load, dwell_dec, dwell_zero;
  logic capture;

  seq_down_counter #(.W(RW)) u_rst_cnt (
    .clk(clk), .rst(rst), .load(rst_load), .load_val(RST_LOAD), .dec(rst_dec), .zero(rst_zero)
  );

  seq_down_counter #(.W(LW)) u_run_cnt (
    .clk(clk), .rst(rst), .load(run_load), .load_val(RUN_LOAD), .dec(run_dec), .zero(run_zero)
  );

  seq_down_counter #(.W(DW)) u_dwell_cnt (
    .clk(clk), .rst(rst), .load(dwell_load), .load_val(DWELL_LOAD), .dec(dwell_dec),
    .zero(dwell_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    rst_load   = 1'b0;
    rst_dec    = 1'b0;
    run_load   = 1'b0;
    run_dec    = 1'b0;
    dwell_load = 1'b0;
    dwell_dec  = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          next_state = S_RESET;
          rst_load   = 1'b1;
        end
      end
      S_RESET: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (rst_zero) begin
          next_state = S_RUN;
          run_load   = 1'b1;
        end else begin
          rst_dec = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          next_state = S_IDLE;
        end else begin
          run_dec = 1'b1;
          if (halt_in || run_zero) begin
            next_state = S_VIEW;
            dwell_load = 1'b1;
          end
        end
      end
      S_VIEW: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (dwell_zero) begin
          capture    = 1'b1;
          dwell_load = 1'b1;
          if (idx == LAST_IDX) next_state = S_DONE;
        end else begin
          dwell_dec = 1'b1;
        end
      end
      S_DONE: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (start) begin
          next_state = S_RESET;
          rst_load   = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rst    <= 1'b1;
      output_sel <= '0;
      rd_valid   <= 1'b0;
      rd_idx     <= '0;
      rd_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      run_cycles <= '0;
      idx        <= '0;
    end else begin
      rd_valid <= 1'b0;
      cpu_rst  <= (next_state == S_IDLE) || (next_state == S_RESET);
      busy     <= (next_state == S_RESET) || (next_state == S_RUN) || (next_state == S_VIEW);
      done     <= (next_state == S_DONE);
      if (rst_load) begin
        timeout    <= 1'b0;
        run_cycles <= '0;
      end
      if (run_dec) begin
        run_cycles <= sat_inc16(run_cycles);
        if (next_state == S_VIEW) begin
          timeout    <= !halt_in;
          idx        <= '0;
          output_sel <= '0;
        end
      end
      if (capture) begin
        rd_valid <= 1'b1;
        rd_idx   <= idx;
        rd_data  <= cpu_output;
        if (next_state != S_DONE) begin
          idx        <= idx + 1'b1;
          output_sel <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Self-checking bench for cpu_run_sequencer with a registered CPU output model
// and expectations derived from the phase lengths of the run/scan sequence.
module tb_cpu_run_sequencer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int RST_C   = 5;
  localparam int RUN_C   = 75;
  localparam int DWELL_C = 2;
  localparam int NREG    = 10;
  localparam int SLOT    = DWELL_C + 1;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0, halt_in = 1'b0;
  logic [DATA_W-1:0] cpu_output = '0;
  logic cpu_rst, rd_valid, busy, done, timeout;
  logic [SEL_W-1:0] output_sel, rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [15:0] run_cycles;

  logic [DATA_W-1:0] base = 32'h100;
  int passed = 0;
  int total  = 0;

  int p_cyc[$];
  int p_idx[$];
  logic [DATA_W-1:0] p_data[$];
  logic p_done[$];
  int done_first;

  cpu_run_sequencer #(
    .DATA_W(DATA_W), .SEL_W(SEL_W), .RST_CYCLES(RST_C), .RUN_CYCLES(RUN_C),
    .DWELL_CYCLES(DWELL_C), .NUM_VIEW_REGS(NREG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .halt_in(halt_in),
    .cpu_output(cpu_output), .cpu_rst(cpu_rst), .output_sel(output_sel),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy),
    .done(done), .timeout(timeout), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // CPU register file view: selected word appears one cycle after output_sel changes.
  always @(posedge clk) cpu_output <= base + 32'(output_sel);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse then RST_C reset cycles; returns with RUN cycle 1 pending.
  task automatic go_to_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RST_C) tick();
  endtask

  // Runs RUN with halt_in raised in cycle h (h > RUN_C means never).
  task automatic run_with_halt(input int h);
    for (int c = 1; c <= RUN_C; c++) begin
      halt_in = (c == h);
      tick();
      if (c == h) break;
    end
    halt_in = 1'b0;
  endtask

  task automatic collect(input int n);
    p_cyc.delete(); p_idx.delete(); p_data.delete(); p_done.delete();
    done_first = -1;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (rd_valid) begin
        p_cyc.push_back(c); p_idx.push_back(int'(rd_idx));
        p_data.push_back(rd_data); p_done.push_back(done);
      end
      if (done && done_first < 0) done_first = c;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (cpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0)
      $display("FAIL reset_vals cpu_rst=%b busy=%b done=%b rd_valid=%b want 1 0 0 0", cpu_rst, busy, done, rd_valid);
    else passed++;
    total++; if (output_sel !== '0 || run_cycles !== 16'd0 || timeout !== 1'b0)
      $display("FAIL reset_cnt sel=%0d run_cycles=%0d timeout=%b want 0 0 0", output_sel, run_cycles, timeout);
    else passed++;
    rst = 1'b0;
    tick();
    total++; if (cpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_vals cpu_rst=%b busy=%b done=%b want 1 0 0", cpu_rst, busy, done);
    else passed++;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= RST_C; i++) begin
      total++; if (cpu_rst !== 1'b1 || busy !== 1'b1)
        $display("FAIL reset_phase cyc=%0d cpu_rst=%b busy=%b want 1 1", i, cpu_rst, busy);
      else passed++;
      if (i < RST_C) tick();
    end
    tick();
    total++; if (cpu_rst !== 1'b0 || busy !== 1'b1 || run_cycles !== 16'd0)
      $display("FAIL run_entry cpu_rst=%b busy=%b run_cycles=%0d want 0 1 0", cpu_rst, busy, run_cycles);
    else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_timeout();
    go_to_run();
    repeat (RUN_C - 1) tick();
    total++; if (run_cycles !== 16'(RUN_C - 1) || timeout !== 1'b0 || cpu_rst !== 1'b0)
      $display("FAIL run_pre_limit run_cycles=%0d timeout=%b cpu_rst=%b want %0d 0 0", run_cycles, timeout, cpu_rst, RUN_C - 1);
    else passed++;
    tick();
    total++; if (run_cycles !== 16'(RUN_C) || timeout !== 1'b1 || busy !== 1'b1)
      $display("FAIL run_limit run_cycles=%0d timeout=%b busy=%b want %0d 1 1", run_cycles, timeout, busy, RUN_C);
    else passed++;
  endtask

  task automatic test_view_scan();
    base = $urandom;
    collect(NREG * SLOT + 3);
    total++; if (p_cyc.size() != NREG)
      $display("FAIL scan_count got=%0d want=%0d", p_cyc.size(), NREG);
    else passed++;
    for (int k = 0; k < p_cyc.size() && k < NREG; k++) begin
      total++;
      if (p_cyc[k] != (k + 1) * SLOT || p_idx[k] != k || p_data[k] !== base + DATA_W'(k) || p_done[k] !== (k == NREG - 1))
        $display("FAIL scan_pulse k=%0d cyc=%0d idx=%0d data=%h done=%b want %0d %0d %h %b", k, p_cyc[k], p_idx[k], p_data[k], p_done[k], (k + 1) * SLOT, k, base + DATA_W'(k), k == NREG - 1);
      else passed++;
    end
    total++; if (done_first != NREG * SLOT)
      $display("FAIL done_rise got=%0d want=%0d", done_first, NREG * SLOT);
    else passed++;
    total++; if (output_sel !== SEL_W'(NREG - 1) || cpu_rst !== 1'b0 || busy !== 1'b0 || done !== 1'b1)
      $display("FAIL done_hold sel=%0d cpu_rst=%b busy=%b done=%b want %0d 0 0 1", output_sel, cpu_rst, busy, done, NREG - 1);
    else passed++;
  endtask

  task automatic test_halt();
    int hs[5];
    hs[0] = 20; hs[1] = RUN_C; hs[2] = 1; hs[3] = int'($urandom_range(2, RUN_C - 1)); hs[4] = RUN_C + 1;
    foreach (hs[i]) begin
      int exp_rc;
      logic exp_to;
      exp_rc = (hs[i] <= RUN_C) ? hs[i] : RUN_C;
      exp_to = (hs[i] > RUN_C);
      go_to_run();
      total++; if (done !== 1'b0 || timeout !== 1'b0)
        $display("FAIL rerun_clear h=%0d done=%b timeout=%b want 0 0", hs[i], done, timeout);
      else passed++;
      run_with_halt(hs[i]);
      total++; if (run_cycles !== 16'(exp_rc) || timeout !== exp_to)
        $display("FAIL halt_run h=%0d run_cycles=%0d timeout=%b want %0d %b", hs[i], run_cycles, timeout, exp_rc, exp_to);
      else passed++;
      collect(NREG * SLOT + 3);
      total++; if (p_cyc.size() != NREG || done !== 1'b1)
        $display("FAIL halt_scan h=%0d pulses=%0d done=%b want %0d 1", hs[i], p_cyc.size(), done, NREG);
      else passed++;
    end
  endtask

  task automatic test_rst_mid_run();
    go_to_run();
    repeat ($urandom_range(5, 60)) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (cpu_rst !== 1'b1 || output_sel !== '0 || rd_valid !== 1'b0 || rd_idx !== '0 || rd_data !== '0)
      $display("FAIL rst_mid_a cpu_rst=%b sel=%0d rd_valid=%b rd_idx=%0d rd_data=%h want 1 0 0 0 0", cpu_rst, output_sel, rd_valid, rd_idx, rd_data);
    else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || run_cycles !== 16'd0)
      $display("FAIL rst_mid_b busy=%b done=%b timeout=%b run_cycles=%0d want 0 0 0 0", busy, done, timeout, run_cycles);
    else passed++;
    collect(12);
    total++; if (p_cyc.size() != 0 || busy !== 1'b0 || cpu_rst !== 1'b1)
      $display("FAIL rst_mid_idle pulses=%0d busy=%b cpu_rst=%b want 0 0 1", p_cyc.size(), busy, cpu_rst);
    else passed++;
  endtask

  task automatic test_abort();
    bit found;
    go_to_run();
    run_with_halt(3);
    found = 1'b0;
    for (int c = 0; c < NREG * SLOT + 5 && !found; c++) begin
      tick();
      if (rd_valid && rd_idx == SEL_W'(4)) found = 1'b1;
    end
    total++; if (!found) $display("FAIL abort_wait_idx4 found=0 want 1");
    else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (cpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0)
      $display("FAIL abort_view cpu_rst=%b busy=%b done=%b rd_valid=%b want 1 0 0 0", cpu_rst, busy, done, rd_valid);
    else passed++;
    collect(NREG * SLOT);
    total++; if (p_cyc.size() != 0 || cpu_rst !== 1'b1)
      $display("FAIL abort_quiet pulses=%0d cpu_rst=%b want 0 1", p_cyc.size(), cpu_rst);
    else passed++;
    // Abort on the very edge that would capture idx 2.
    go_to_run();
    run_with_halt(2);
    found = 1'b0;
    for (int c = 0; c < NREG * SLOT + 5 && !found; c++) begin
      tick();
      if (rd_valid && rd_idx == SEL_W'(1)) found = 1'b1;
    end
    repeat (SLOT - 1) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (!found || rd_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_capture found=%b rd_valid=%b busy=%b want 1 0 0", found, rd_valid, busy);
    else passed++;
    go_to_run();
    run_with_halt(4);
    collect(NREG * SLOT + 3);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || cpu_rst !== 1'b1)
      $display("FAIL abort_start busy=%b done=%b cpu_rst=%b want 0 0 1", busy, done, cpu_rst);
    else passed++;
    repeat (RST_C + 2) tick();
    total++; if (busy !== 1'b0 || cpu_rst !== 1'b1)
      $display("FAIL abort_start_stay busy=%b cpu_rst=%b want 0 1", busy, cpu_rst);
    else passed++;
  endtask

  task automatic test_back_to_back();
    base = 32'h100;
    go_to_run();
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (run_cycles !== 16'd11 || busy !== 1'b1 || cpu_rst !== 1'b0)
      $display("FAIL start_in_run run_cycles=%0d busy=%b cpu_rst=%b want 11 1 0", run_cycles, busy, cpu_rst);
    else passed++;
    repeat (RUN_C - 11) tick();
    total++; if (run_cycles !== 16'(RUN_C) || timeout !== 1'b1)
      $display("FAIL start_in_run_end run_cycles=%0d timeout=%b want %0d 1", run_cycles, timeout, RUN_C);
    else passed++;
    collect(NREG * SLOT + 3);
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (done !== 1'b0 || busy !== 1'b1 || cpu_rst !== 1'b1 || run_cycles !== 16'd0 || timeout !== 1'b0)
          $display("FAIL rerun_start done=%b busy=%b cpu_rst=%b run_cycles=%0d timeout=%b want 0 1 1 0 0", done, busy, cpu_rst, run_cycles, timeout);
        else passed++;
        repeat (RST_C - 1 + RUN_C + 1) tick();
        total++; if (run_cycles !== 16'(RUN_C) || timeout !== 1'b1)
          $display("FAIL rerun_limit run_cycles=%0d timeout=%b want %0d 1", run_cycles, timeout, RUN_C);
        else passed++;
        collect(NREG * SLOT + 3);
      end
      total++; if (p_cyc.size() != NREG)
        $display("FAIL b2b_count run=%0d got=%0d want=%0d", r, p_cyc.size(), NREG);
      else passed++;
      for (int k = 0; k < p_cyc.size() && k < NREG; k++) begin
        total++;
        if (p_cyc[k] != (k + 1) * SLOT || p_idx[k] != k || p_data[k] !== 32'h100 + DATA_W'(k))
          $display("FAIL b2b_pulse run=%0d k=%0d cyc=%0d idx=%0d data=%h want %0d %0d %h", r, k, p_cyc[k], p_idx[k], p_data[k], (k + 1) * SLOT, k, 32'h100 + DATA_W'(k));
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_view_scan();
    test_halt();
    test_rst_mid_run();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
